// File: rtl/mux_if.sv
// Bus bundle for the registered 2:1 word selector: two data sources,
// a select line and the registered result.
interface mux_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic             sel;
    logic [WIDTH-1:0] out;

    // Producer of the sources; observes the selected result.
    modport master (
        output data0,
        output data1,
        output sel,
        input  out
    );

    // The selector itself.
    modport slave (
        input  data0,
        input  data1,
        input  sel,
        output out
    );
endinterface

// File: rtl/mux.sv
// Registered 2:1 word selector for the RV32I datapath. The selected
// source is captured on each rising edge, so out is a clean flop output
// with exactly one cycle of latency and no combinational input path.
module mux #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst,
    mux_if.slave  bus
);
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;

    // Pick the source that the next edge will capture.
    always_comb begin
        out_d = bus.sel ? bus.data1 : bus.data0;
    end

    // Output register; synchronous reset has priority over the selection.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.out = out_q;
endmodule

// File: tb/tb_mux.sv
// Directed bench for the registered 2:1 selector: reset, selection,
// one-cycle latency, hold between edges and mid-operation reset.
module tb_mux;
    localparam int WIDTH = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    mux_if #(.WIDTH(WIDTH)) bus ();

    mux #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are driven and outputs
    // sampled 2 time units after it, well away from the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [WIDTH-1:0] exp);
        n_checks++;
        assert (bus.out === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, bus.out, exp);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] exp_v;
        logic [WIDTH-1:0] prev_v;
        n_checks = 0;
        n_fails  = 0;

        // Reset held for two edges with data1 selected.
        rst       = 1'b1;
        bus.data0 = 32'h0000_0001;
        bus.data1 = 32'hFFFF_FFFE;
        bus.sel   = 1'b1;
        tick();
        chk("reset_edge1", 32'h0000_0000);
        tick();
        chk("reset_edge2", 32'h0000_0000);

        // Release reset selecting data0: no dead cycle.
        rst     = 1'b0;
        bus.sel = 1'b0;
        tick();
        chk("sel_data0", 32'h0000_0001);

        // Switch to data1 mid-cycle: out holds until the edge.
        bus.sel = 1'b1;
        #1;
        chk("hold_before_edge", 32'h0000_0001);
        tick();
        chk("sel_data1", 32'hFFFF_FFFE);

        // Selected input update propagates; unselected one does not.
        bus.data1 = 32'h0000_0002;
        tick();
        chk("data1_update", 32'h0000_0002);
        bus.data0 = 32'hDEAD_BEEF;
        tick();
        chk("unselected_change", 32'h0000_0002);

        // Reset mid-operation, then release selecting data0.
        rst = 1'b1;
        tick();
        chk("reset_mid_op", 32'h0000_0000);
        rst     = 1'b0;
        bus.sel = 1'b0;
        tick();
        chk("release_data0", 32'hDEAD_BEEF);

        // Simultaneous change of sel and data: the edge-sampled pair wins.
        bus.sel   = 1'b1;
        bus.data1 = 32'h1234_5678;
        tick();
        chk("simultaneous", 32'h1234_5678);

        // Toggle sel every cycle: out follows sel with one cycle of lag.
        bus.data0 = 32'hAAAA_AAAA;
        bus.data1 = 32'h5555_5555;
        prev_v    = 32'h1234_5678;
        for (int i = 0; i < 6; i++) begin
            bus.sel = i[0];
            exp_v   = i[0] ? 32'h5555_5555 : 32'hAAAA_AAAA;
            #1;
            chk($sformatf("toggle_hold_%0d", i), prev_v);
            tick();
            chk($sformatf("toggle_out_%0d", i), exp_v);
            prev_v = exp_v;
        end

        // Reset held again keeps out at zero regardless of inputs.
        rst = 1'b1;
        tick();
        chk("reset_again1", 32'h0000_0000);
        bus.sel = 1'b0;
        tick();
        chk("reset_again2", 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
